// File: rtl/pwm_cfg_update_ctrl.sv
// Shadows a PWM configuration bundle and commits it atomically at the period boundary,
// immediately when the PWM is disabled, or by force after MAX_WAIT stalled cycles.
module pwm_cfg_update_ctrl #(
  parameter int unsigned MAX_WAIT = 1024,
  parameter int unsigned WAIT_W   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_functions,
  input  logic [15:0] cfg_compare1,
  input  logic [15:0] cfg_compare2,
  input  logic        cfg_en,
  input  logic        cfg_abort,
  input  logic [15:0] count_val,
  output logic [15:0] period,
  output logic [7:0]  functions,
  output logic [15:0] compare1,
  output logic [15:0] compare2,
  output logic        pwm_en,
  output logic        cnt_clr,
  output logic        update_done,
  output logic        update_forced,
  output logic        cfg_err
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  logic [15:0]       sh_period;
  logic [7:0]        sh_functions;
  logic [15:0]       sh_compare1;
  logic [15:0]       sh_compare2;
  logic              sh_en;
  logic [WAIT_W-1:0] wait_cnt;

  logic do_commit;
  logic do_clr;
  logic do_forced;
  logic timeout;

  // Unaligned mode needs compare1 <= compare2 to produce a sane pulse window.
  function automatic logic bundle_bad(input logic [7:0] fn, input logic [15:0] c1,
                                      input logic [15:0] c2);
    return fn[1] && (c1 > c2);
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] w);
    return (&w) ? w : w + WAIT_W'(1);
  endfunction

  assign timeout = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

  // Commit decision in priority order; abort suppresses everything.
  always_comb begin
    do_commit = 1'b0;
    do_clr    = 1'b0;
    do_forced = 1'b0;
    if (state == PENDING && !cfg_abort) begin
      if (!pwm_en) begin
        do_commit = 1'b1;
        do_clr    = sh_en;
      end else if (count_val == period) begin
        do_commit = 1'b1;
      end else if (timeout) begin
        do_commit = 1'b1;
        do_clr    = 1'b1;
        do_forced = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cfg_ready     <= 1'b1;
      sh_period     <= '0;
      sh_functions  <= '0;
      sh_compare1   <= '0;
      sh_compare2   <= '0;
      sh_en         <= 1'b0;
      wait_cnt      <= '0;
      period        <= '0;
      functions     <= '0;
      compare1      <= '0;
      compare2      <= '0;
      pwm_en        <= 1'b0;
      cnt_clr       <= 1'b0;
      update_done   <= 1'b0;
      update_forced <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cnt_clr       <= 1'b0;
      update_done   <= 1'b0;
      update_forced <= 1'b0;
      cfg_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (bundle_bad(cfg_functions, cfg_compare1, cfg_compare2)) begin
              cfg_err <= 1'b1;
            end else begin
              sh_period    <= cfg_period;
              sh_functions <= cfg_functions;
              sh_compare1  <= cfg_compare1;
              sh_compare2  <= cfg_compare2;
              sh_en        <= cfg_en;
              wait_cnt     <= '0;
              state        <= PENDING;
              cfg_ready    <= 1'b0;
            end
          end
        end
        PENDING: begin
          if (cfg_abort) begin
            sh_period    <= '0;
            sh_functions <= '0;
            sh_compare1  <= '0;
            sh_compare2  <= '0;
            sh_en        <= 1'b0;
            state        <= IDLE;
            cfg_ready    <= 1'b1;
          end else if (do_commit) begin
            period        <= sh_period;
            functions     <= sh_functions;
            compare1      <= sh_compare1;
            compare2      <= sh_compare2;
            pwm_en        <= sh_en;
            cnt_clr       <= do_clr;
            update_done   <= 1'b1;
            update_forced <= do_forced;
            state         <= IDLE;
            cfg_ready     <= 1'b1;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
